igniter_sequencer: RTL and testbench

Command-side controller for the candle igniter carriage. It accepts queued "light candle N" requests and mirrors the carriage position. For each request it plans a forward-only path around the 8-slot ring and drives the carriage's `enable_move`/`delta` step interface. After the carriage settles at the target slot, it holds the ignite strobe for a fixed dwell. It sits between the user/command decoder and the igniter position register, and is the initiator of that step interface.

---
 rtl/igniter_sequencer.sv | 124 ++++++++++++
 tb/tb_igniter_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/igniter_sequencer.sv
// Igniter carriage command sequencer: queues "light candle N" requests, plans forward-only
// moves around the 8-slot ring, drives the move strobe, then holds ignite for a fixed dwell.
module igniter_sequencer #(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_STEP      = 7,
  parameter int SETTLE_CYCLES = 4,
  parameter int IGNITE_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       clr,
  input  logic       req_valid,
  input  logic [2:0] req_target,
  output logic       req_ready,
  input  logic       abort,
  output logic       enable_move,
  output logic [3:0] delta,
  output logic [2:0] position_q,
  output logic       ignite,
  output logic       busy,
  output logic       done_pulse,
  output logic [2:0] done_pos,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE   = 3'd1,
    S_SETTLE = 3'd2,
    S_IGNITE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_MAX = (SETTLE_CYCLES > IGNITE_CYCLES) ? SETTLE_CYCLES : IGNITE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [2:0]       STEP_MAX    = 3'(MAX_STEP);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] IGNITE_LAST = CNT_W'(IGNITE_CYCLES - 1);
  localparam logic [PTR_W:0]   FIFO_FULL   = (PTR_W + 1)'(FIFO_DEPTH);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       remaining;
  logic [2:0]       step;
  logic [2:0]       rem_init;
  logic [2:0]       done_pos_r;

  logic [2:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             full, empty, push, pop;

  // Handshake: a request transfers on any rising edge where req_valid && req_ready;
  // req_ready drops while full or while abort is asserted, so an abort cycle never enqueues.
  assign full      = (count == FIFO_FULL);
  assign empty     = (count == '0);
  assign req_ready = !full && !abort;
  assign push      = req_valid && req_ready;
  assign pop       = (state == S_IDLE) && !empty && !abort;
  assign rem_init  = fifo_mem[rd_ptr] - position_q;

  always_ff @(posedge sys_clk) begin
    if (push) fifo_mem[wr_ptr] <= req_target;
  end

  always_ff @(posedge sys_clk) begin
    if (clr || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    step       = (remaining > STEP_MAX) ? STEP_MAX : remaining;
    case (state)
      S_IDLE:   if (pop) state_next = (rem_init == 3'd0) ? S_IGNITE : S_MOVE;
      S_MOVE:   state_next = S_SETTLE;
      S_SETTLE: if (cnt == SETTLE_LAST) state_next = (remaining != 3'd0) ? S_MOVE : S_IGNITE;
      S_IGNITE: if (cnt == IGNITE_LAST) state_next = S_DONE;
      S_DONE:   state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (abort) state_next = S_IDLE;
  end

  // A MOVE pulse is already on the wire, so the mirror follows it even under abort.
  always_ff @(posedge sys_clk) begin
    if (clr) begin
      state      <= S_IDLE;
      cnt        <= '0;
      remaining  <= '0;
      position_q <= '0;
      done_pos_r <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? '0 : cnt + CNT_W'(1);
      if (pop) remaining <= rem_init;
      if (state == S_MOVE) begin
        position_q <= position_q + step;
        remaining  <= remaining - step;
      end
      if (state == S_IGNITE && state_next == S_DONE) done_pos_r <= position_q;
    end
  end

  assign enable_move = (state == S_MOVE);
  assign delta       = (state == S_MOVE) ? {1'b0, step} : 4'd0;
  assign ignite      = (state == S_IGNITE);
  assign busy        = (state != S_IDLE);
  assign done_pulse  = (state == S_DONE);
  assign done_pos    = done_pos_r;
  assign state_dbg   = state;

endmodule

// File: tb/tb_igniter_sequencer.sv
// Directed bench for igniter_sequencer: a job table checked cycle by cycle against a
// hand-derived timeline, plus queue-fill, abort and clear sequences.
module tb_igniter_sequencer;

  localparam int SETTLE = 4;
  localparam int IGN    = 16;
  localparam int PER    = 1 + SETTLE;

  logic       sys_clk = 1'b0;
  logic       clr = 1'b1;
  logic       req_valid = 1'b0, req_valid3 = 1'b0;
  logic [2:0] req_target = 3'd0;
  logic       abort = 1'b0;

  logic       req_ready, enable_move, ignite, busy, done_pulse;
  logic [3:0] delta;
  logic [2:0] position_q, done_pos, state_dbg;
  logic       req_ready3, enable_move3, ignite3, busy3, done_pulse3;
  logic [3:0] delta3;
  logic [2:0] position_q3, done_pos3, state_dbg3;

  int errors = 0;
  int checks = 0;
  logic [2:0] mpos = 3'd0, mpos3 = 3'd0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [2:0] target;
    int         n;
    logic [2:0] d0, d1, d2;
    logic [2:0] exp_pos;
  } job_t;
  job_t jobs[5];

  always #5 sys_clk = ~sys_clk;

  igniter_sequencer dut (
    .sys_clk(sys_clk), .clr(clr), .req_valid(req_valid), .req_target(req_target),
    .req_ready(req_ready), .abort(abort), .enable_move(enable_move), .delta(delta),
    .position_q(position_q), .ignite(ignite), .busy(busy), .done_pulse(done_pulse),
    .done_pos(done_pos), .state_dbg(state_dbg)
  );

  igniter_sequencer #(.MAX_STEP(3)) dut3 (
    .sys_clk(sys_clk), .clr(clr), .req_valid(req_valid3), .req_target(req_target),
    .req_ready(req_ready3), .abort(abort), .enable_move(enable_move3), .delta(delta3),
    .position_q(position_q3), .ignite(ignite3), .busy(busy3), .done_pulse(done_pulse3),
    .done_pos(done_pos3), .state_dbg(state_dbg3)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {enable_move, delta, position_q, ignite, busy, done_pulse}
  task automatic get_outs(input bit use3, output logic [10:0] vec, output logic [2:0] dpos,
                          output logic rdy);
    if (use3) begin
      vec  = {enable_move3, delta3, position_q3, ignite3, busy3, done_pulse3};
      dpos = done_pos3;
      rdy  = req_ready3;
    end else begin
      vec  = {enable_move, delta, position_q, ignite, busy, done_pulse};
      dpos = done_pos;
      rdy  = req_ready;
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run_job(input bit use3, input logic [2:0] tgt, input int n,
                         input logic [2:0] d0, input logic [2:0] d1, input logic [2:0] d2,
                         input logic [2:0] exp_pos);
    logic [2:0]  dd[3];
    logic [10:0] vec, exp_vec;
    logic [2:0]  dpos, p;
    logic        rdy, en, ign, bsy, dn;
    logic [3:0]  dl;
    int          ign_start, total;
    dd[0] = d0; dd[1] = d1; dd[2] = d2;
    p = use3 ? mpos3 : mpos;
    ign_start = 1 + n * PER;
    total     = ign_start + IGN + 1;
    req_target = tgt;
    if (use3) req_valid3 = 1'b1; else req_valid = 1'b1;
    #1;
    get_outs(use3, vec, dpos, rdy);
    check($sformatf("job%0d ready", tgt), {31'd0, rdy}, 32'd1);
    tick();
    req_valid = 1'b0;
    req_valid3 = 1'b0;
    for (int k = 0; k <= total; k++) begin
      en = 1'b0; dl = 4'd0; ign = 1'b0; dn = 1'b0;
      bsy = (k >= 1) && (k < total);
      if (k >= 1 && (k - 1) < n * PER && ((k - 1) % PER) == 0) begin
        en = 1'b1;
        dl = {1'b0, dd[(k - 1) / PER]};
      end
      if (k >= ign_start && k < ign_start + IGN) ign = 1'b1;
      if (k == ign_start + IGN) dn = 1'b1;
      exp_vec = {en, dl, p, ign, bsy, dn};
      get_outs(use3, vec, dpos, rdy);
      check($sformatf("job%0d k=%0d outs", tgt, k), {21'd0, vec}, {21'd0, exp_vec});
      if (dn) check($sformatf("job%0d done_pos", tgt), {29'd0, dpos}, {29'd0, exp_pos});
      if (en) p = p + dl[2:0];
      if (k < total) tick();
    end
    check($sformatf("job%0d done_pos hold", tgt), {29'd0, dpos}, {29'd0, exp_pos});
    if (use3) mpos3 = p; else mpos = p;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [10:0] vec;
    logic [2:0]  dpos, got;
    logic        rdy, seen_busy, seen_done;
    logic [2:0]  fill_t[5];

    jobs[0] = '{target: 3'd5, n: 1, d0: 3'd5, d1: 3'd0, d2: 3'd0, exp_pos: 3'd5};
    jobs[1] = '{target: 3'd2, n: 1, d0: 3'd5, d1: 3'd0, d2: 3'd0, exp_pos: 3'd2};
    jobs[2] = '{target: 3'd2, n: 0, d0: 3'd0, d1: 3'd0, d2: 3'd0, exp_pos: 3'd2};
    jobs[3] = '{target: 3'd1, n: 1, d0: 3'd7, d1: 3'd0, d2: 3'd0, exp_pos: 3'd1};
    jobs[4] = '{target: 3'd0, n: 1, d0: 3'd7, d1: 3'd0, d2: 3'd0, exp_pos: 3'd0};
    fill_t[0] = 3'd6; fill_t[1] = 3'd1; fill_t[2] = 3'd4; fill_t[3] = 3'd7; fill_t[4] = 3'd5;

    // reset
    tick();
    get_outs(1'b0, vec, dpos, rdy);
    check("reset outs", {21'd0, vec}, 32'd0);
    check("reset done_pos", {29'd0, dpos}, 32'd0);
    check("reset ready", {31'd0, rdy}, 32'd1);
    tick();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      get_outs(1'b0, vec, dpos, rdy);
      check("post-reset idle", {21'd0, vec}, 32'd0);
    end

    // MAX_STEP=3 instance: 0 -> 7 in pulses 3,3,1
    run_job(1'b1, 3'd7, 3, 3'd3, 3'd3, 3'd1, 3'd7);
    tick();

    for (int j = 0; j < 5; j++) begin
      run_job(1'b0, jobs[j].target, jobs[j].n, jobs[j].d0, jobs[j].d1, jobs[j].d2,
              jobs[j].exp_pos);
      tick();
    end

    // queue fill: one job running, then five back-to-back pushes
    req_target = 3'd3;
    req_valid  = 1'b1;
    exp_q.push_back(3'd3);
    tick();
    for (int i = 0; i < 5; i++) begin
      req_target = fill_t[i];
      #1;
      check($sformatf("fill ready %0d", i), {31'd0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
      if (i < 4) exp_q.push_back(fill_t[i]);
      tick();
    end
    req_valid = 1'b0;
    for (int c = 0; c < 800 && exp_q.size() > 0; c++) begin
      if (done_pulse) begin
        got = exp_q.pop_front();
        check("fill order done_pos", {29'd0, done_pos}, {29'd0, got});
      end
      if (exp_q.size() > 0) tick();
    end
    check("fill jobs remaining", exp_q.size(), 32'd0);
    seen_busy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      seen_busy |= busy;
    end
    check("fill queue drained", {31'd0, seen_busy}, 32'd0);
    check("fill position", {29'd0, position_q}, 32'd7);
    mpos = 3'd7;

    // abort mid-IGNITE with two requests queued
    req_target = 3'd7;
    req_valid  = 1'b1;
    tick();
    req_target = 3'd1;
    tick();
    req_target = 3'd2;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("abort pre ignite", {31'd0, ignite}, 32'd1);
    abort      = 1'b1;
    req_valid  = 1'b1;
    req_target = 3'd4;
    #1;
    check("abort ready low", {31'd0, req_ready}, 32'd0);
    tick();
    abort     = 1'b0;
    req_valid = 1'b0;
    check("abort outs", {21'd0, enable_move, delta, position_q, ignite, busy, done_pulse},
          {21'd0, 1'b0, 4'd0, 3'd7, 1'b0, 1'b0, 1'b0});
    seen_busy = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 30; c++) begin
      tick();
      seen_busy |= busy;
      seen_done |= done_pulse;
    end
    check("abort flushed", {31'd0, seen_busy}, 32'd0);
    check("abort no done", {31'd0, seen_done}, 32'd0);
    check("abort ready back", {31'd0, req_ready}, 32'd1);

    // clr during SETTLE: 7 -> 3 is one pulse of 4
    req_target = 3'd3;
    req_valid  = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    check("clr-test pulse", {27'd0, enable_move, delta}, {27'd0, 1'b1, 4'd4});
    tick();
    check("clr-test settle pos", {28'd0, busy, position_q}, {28'd0, 1'b1, 3'd3});
    clr = 1'b1;
    tick();
    clr = 1'b0;
    get_outs(1'b0, vec, dpos, rdy);
    check("clr outs", {21'd0, vec}, 32'd0);
    check("clr done_pos", {29'd0, dpos}, 32'd0);
    check("clr ready", {31'd0, rdy}, 32'd1);
    mpos  = 3'd0;
    mpos3 = 3'd0;
    tick();
    run_job(1'b0, 3'd2, 1, 3'd2, 3'd0, 3'd0, 3'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
